// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one external combinational ALU between two requesters. A request
//   is accepted in IDLE (round-robin on ties), its operands are latched and
//   held on the ALU inputs, the ALU result is captured one cycle later, and
//   the result is returned with a one-cycle done pulse to the owner.
//
//   Timeline for a grant at edge N:
//     edge N   : grant, operands latched, ack pulse (IDLE -> EXEC)
//     edge N+1 : alu_res/zero/overflow captured, done pulse (EXEC -> RESP)
//     edge N+2 : RESP -> IDLE
//     edge N+3 : earliest next grant
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req0, a0, b0, op0       requester 0 request and operation fields
//   req1, a1, b1, op1       requester 1 request and operation fields
//   ack0, ack1              one-cycle acceptance pulses
//   done0, done1            one-cycle result-valid pulses
//   res, zero, overflow     registered ALU result for the done owner
//   alu_A, alu_B, alu_op    drive the shared ALU (from latched operands)
//   alu_res, alu_zero,
//   alu_overflow            results returned by the shared ALU
//   busy                    high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [2:0]   op0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [2:0]   op1,
  output logic         ack0,
  output logic         ack1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] res,
  output logic         zero,
  output logic         overflow,
  output logic [W-1:0] alu_A,
  output logic [W-1:0] alu_B,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_res,
  input  logic         alu_zero,
  input  logic         alu_overflow,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  logic [1:0]   r_state;
  logic         r_last_gnt;   // index granted most recently
  logic         r_gnt;        // owner of the operation in flight
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [2:0]   r_op;
  logic [W-1:0] r_res;
  logic         r_zero;
  logic         r_ovf;
  logic         r_ack0;
  logic         r_ack1;
  logic         r_done0;
  logic         r_done1;

  logic         w_any_req;
  logic         w_pick1;

  // Requester 1 wins when it is alone, or when both ask and 0 was served last.
  assign w_any_req = req0 | req1;
  assign w_pick1   = req1 & (~req0 | ~r_last_gnt);

  // The ALU always sees the latched operands, so requester inputs never leak
  // onto the shared bus and a requester may change its fields after ack.
  assign alu_A    = r_a;
  assign alu_B    = r_b;
  assign alu_op   = r_op;

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign done0    = r_done0;
  assign done1    = r_done1;
  assign res      = r_res;
  assign zero     = r_zero;
  assign overflow = r_ovf;
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;     // makes requester 0 win the first tie
      r_gnt      <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 3'b000;
      r_res      <= '0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state    <= EXEC;
            r_gnt      <= w_pick1;
            r_last_gnt <= w_pick1;
            r_a        <= w_pick1 ? a1  : a0;
            r_b        <= w_pick1 ? b1  : b0;
            r_op       <= w_pick1 ? op1 : op0;
            r_ack0     <= ~w_pick1;
            r_ack1     <= w_pick1;
          end
        end
        EXEC: begin
          // Done is registered here so it is high for the whole RESP cycle,
          // together with the freshly captured result.
          r_res   <= alu_res;
          r_zero  <= alu_zero;
          r_ovf   <= alu_overflow;
          r_done0 <= ~r_gnt;
          r_done1 <= r_gnt;
          r_state <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [2:0]   op0, op1;
  logic         ack0, ack1, done0, done1;
  logic [W-1:0] res;
  logic         zero, overflow;
  logic [W-1:0] alu_A, alu_B;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_res;
  logic         alu_zero, alu_overflow;
  logic         busy;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0         (req0),
    .a0           (a0),
    .b0           (b0),
    .op0          (op0),
    .req1         (req1),
    .a1           (a1),
    .b1           (b1),
    .op1          (op1),
    .ack0         (ack0),
    .ack1         (ack1),
    .done0        (done0),
    .done1        (done1),
    .res          (res),
    .zero         (zero),
    .overflow     (overflow),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_op       (alu_op),
    .alu_res      (alu_res),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .busy         (busy)
  );

  // Shared ALU attached to the arbiter:
  // 000 SUB, 001 AND, 010 OR, 011 SLL, 100 SRL, 101 NOR, 110 XOR, 111 ADD
  always_comb begin
    alu_res      = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_res      = alu_A - alu_B;
        alu_overflow = (alu_A[W-1] != alu_B[W-1]) && (alu_res[W-1] != alu_A[W-1]);
      end
      3'b001: alu_res = alu_A & alu_B;
      3'b010: alu_res = alu_A | alu_B;
      3'b011: alu_res = alu_A << alu_B[4:0];
      3'b100: alu_res = alu_A >> alu_B[4:0];
      3'b101: alu_res = ~(alu_A | alu_B);
      3'b110: alu_res = alu_A ^ alu_B;
      default: begin
        alu_res      = alu_A + alu_B;
        alu_overflow = (alu_A[W-1] == alu_B[W-1]) && (alu_res[W-1] != alu_A[W-1]);
      end
    endcase
    alu_zero = (alu_res == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from IDLE; optionally corrupts the requester's
  // fields right after ack to show the in-flight operation is unaffected.
  task automatic run_op(input string tag, input logic ch,
                        input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [31:0] er, input logic ez, input logic eo,
                        input logic corrupt);
    if (!ch) begin a0 = a; b0 = b; op0 = op; req0 = 1'b1; end
    else     begin a1 = a; b1 = b; op1 = op; req1 = 1'b1; end
    step();
    check({tag, "_ack0"}, ack0, !ch);
    check({tag, "_ack1"}, ack1, ch);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_dn_early"}, done0 | done1, 1'b0);
    check({tag, "_aluA"}, alu_A, a);
    check({tag, "_aluB"}, alu_B, b);
    check({tag, "_aluop"}, alu_op, op);
    req0 = 1'b0;
    req1 = 1'b0;
    if (corrupt) begin
      a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF; op0 = ~op;
      a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; op1 = ~op;
    end
    step();
    check({tag, "_done0"}, done0, !ch);
    check({tag, "_done1"}, done1, ch);
    check({tag, "_ackoff"}, ack0 | ack1, 1'b0);
    check({tag, "_res"}, res, er);
    check({tag, "_zero"}, zero, ez);
    check({tag, "_ovf"}, overflow, eo);
    step();
    check({tag, "_dn_off"}, done0 | done1, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_hold_res"}, res, er);
    check({tag, "_hold_aluA"}, alu_A, a);
  endtask

  logic [31:0] ops_exp [8];
  logic [31:0] rr_res;

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; op0 = '0;
    a1 = '0; b1 = '0; op1 = '0;
    #2;
    check("rst_ack", {ack0, ack1}, 2'b00);
    check("rst_done", {done0, done1}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_flags", {zero, overflow}, 2'b00);
    check("rst_res", res, 32'h0);
    check("rst_aluA", alu_A, 32'h0);
    check("rst_aluB", alu_B, 32'h0);
    check("rst_aluop", alu_op, 3'b000);
    rst_n = 1'b1;

    // First edge after release: ack0 at edge 1, done0 in cycle 3.
    run_op("add", 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'b111, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("or1", 1'b1, 32'h0123_4567, 32'h7654_3210, 3'b010, 32'h7777_7777, 1'b0, 1'b0, 1'b0);
    run_op("hold", 1'b0, 32'h0000_1000, 32'h0000_0234, 3'b111, 32'h0000_1234, 1'b0, 1'b0, 1'b1);
    run_op("xor0", 1'b0, 32'h1234_5678, 32'h1234_5678, 3'b110, 32'h0, 1'b1, 1'b0, 1'b0);

    // All eight op codes, a=F0 b=4.
    ops_exp[0] = 32'h0000_00EC;
    ops_exp[1] = 32'h0000_0000;
    ops_exp[2] = 32'h0000_00F4;
    ops_exp[3] = 32'h0000_0F00;
    ops_exp[4] = 32'h0000_000F;
    ops_exp[5] = 32'hFFFF_FF0B;
    ops_exp[6] = 32'h0000_00F4;
    ops_exp[7] = 32'h0000_00F4;
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("op%0d", i), i[0], 32'h0000_00F0, 32'h0000_0004, i[2:0],
             ops_exp[i], (ops_exp[i] == 32'h0), 1'b0, 1'b0);
    end

    run_op("addovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b111, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("subovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 3'b000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);

    // Reset asserted during EXEC aborts the operation.
    a0 = 32'h0000_0005; b0 = 32'h0000_0006; op0 = 3'b111; req0 = 1'b1;
    step();
    check("ab_ack0", ack0, 1'b1);
    req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("ab_busy", busy, 1'b0);
    check("ab_ack", {ack0, ack1}, 2'b00);
    check("ab_done", {done0, done1}, 2'b00);
    check("ab_res", res, 32'h0);
    check("ab_flags", {zero, overflow}, 2'b00);
    check("ab_aluA", alu_A, 32'h0);
    check("ab_aluop", alu_op, 3'b000);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ab_nodone", {done0, done1}, 2'b00);
      check("ab_idle", busy, 1'b0);
    end

    // Round robin with both requests held after a fresh reset: 0,1,0,1.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    a0 = 32'h1; b0 = 32'h2; op0 = 3'b111;
    a1 = 32'h10; b1 = 32'h20; op1 = 3'b111;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rr_res = k[0] ? 32'h30 : 32'h3;
      step();
      check($sformatf("rr%0d_ack0", k), ack0, !k[0]);
      check($sformatf("rr%0d_ack1", k), ack1, k[0]);
      check($sformatf("rr%0d_mutex", k), ack0 & ack1, 1'b0);
      step();
      check($sformatf("rr%0d_done0", k), done0, !k[0]);
      check($sformatf("rr%0d_done1", k), done1, k[0]);
      check($sformatf("rr%0d_res", k), res, rr_res);
      step();
      check($sformatf("rr%0d_gap", k), {ack0, ack1, done0, done1}, 4'b0000);
      check($sformatf("rr%0d_idle", k), busy, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("end_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
